// File: rtl/dac_pkg.sv
// ============================================================================
// Module      : dac_pkg
// Description : Shared constants, mode/state encodings and helpers for the
//               DAC sample-source blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dac_pkg;

  localparam int DAC_W = 14;
  localparam logic [DAC_W-1:0] DAC_MID = 14'h1FFF;
  localparam logic [DAC_W-1:0] DAC_MAX = 14'h3FFF;

  localparam logic [7:0] DAC_CTRL_STEADY = 8'd0;
  localparam logic [7:0] DAC_CTRL_RAMP   = 8'd1;

  localparam logic [1:0] MODE_SAW  = 2'd0;
  localparam logic [1:0] MODE_TRI  = 2'd1;
  localparam logic [1:0] MODE_HOLD = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_UP     = 3'd1;
  localparam logic [2:0] ST_DOWN   = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  function automatic logic [DAC_W-1:0] dac_clamp(input logic [DAC_W-1:0] v,
                                                 input logic [DAC_W-1:0] lo,
                                                 input logic [DAC_W-1:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dac_sweep_gen_if.sv
// ============================================================================
// Module      : dac_sweep_gen_if
// Description : Control/sample bus of the sweep generator. Optional limit
//               inputs exist only when DAC_SWEEP_LIMIT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dac_sweep_gen_if #(
  parameter int DATA_W = 14,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 8
);
  logic              start;
  logic              stop;
  logic [1:0]        mode;
  logic [DATA_W-1:0] step;
  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  n_cycles;
`ifdef DAC_SWEEP_LIMIT_EN
  logic [DATA_W-1:0] lo_lim;
  logic [DATA_W-1:0] hi_lim;
`endif
  logic              busy;
  logic              done;
  logic              sample_stb;
  logic [DATA_W-1:0] data;
  logic [7:0]        control;

`ifdef DAC_SWEEP_LIMIT_EN
  modport master (output start, stop, mode, step, div, n_cycles, lo_lim, hi_lim,
                  input  busy, done, sample_stb, data, control);
  modport slave  (input  start, stop, mode, step, div, n_cycles, lo_lim, hi_lim,
                  output busy, done, sample_stb, data, control);
`else
  modport master (output start, stop, mode, step, div, n_cycles,
                  input  busy, done, sample_stb, data, control);
  modport slave  (input  start, stop, mode, step, div, n_cycles,
                  output busy, done, sample_stb, data, control);
`endif

endinterface

`default_nettype wire

// File: rtl/sample_rate_div.sv
// ============================================================================
// Module      : sample_rate_div
// Description : Sample-period divider; tick is high for one clock every div+1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_rate_div #(
  parameter int DIV_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear,
  input  wire logic [DIV_W-1:0] div,
  output logic                  tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    tick = (cnt_q == div);
    if (clear || tick) cnt_d = '0;
    else               cnt_d = cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/dac_sweep_gen.sv
// ============================================================================
// Module      : dac_sweep_gen
// Description : Sawtooth / triangle / hold-level sample source for the DAC904
//               driver. Define DAC_SWEEP_LIMIT_EN for programmable bounds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_sweep_gen
  import dac_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 8
) (
  input wire logic        clk,
  input wire logic        rst,
  dac_sweep_gen_if.slave  bus
);

  localparam logic [DATA_W-1:0] C_MID = DATA_W'(DAC_MID);
  localparam logic [DATA_W-1:0] C_MAX = DATA_W'(DAC_MAX);
  localparam logic [DATA_W-1:0] C_ONE = DATA_W'(1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] step_q;
  logic [DIV_W-1:0]  div_q;
  logic [CNT_W-1:0]  ncyc_q;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              stb_q, stb_d;
  logic              pend_q, pend_d;

  logic              w_tick;
  logic              w_start_ok;
  logic              w_capture;
  logic              w_wrap;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_lo;
  logic [DATA_W-1:0] w_hi;
  logic [DATA_W-1:0] w_first;
  logic [DATA_W-1:0] w_step_in;

  // Zero step would stall a ramp forever, so ramps treat it as one LSB.
  assign w_step_in = ((bus.mode != MODE_HOLD) && (bus.step == '0)) ? C_ONE : bus.step;

`ifdef DAC_SWEEP_LIMIT_EN
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] hi_q;

  assign w_lo       = lo_q;
  assign w_hi       = hi_q;
  assign w_start_ok = bus.start && !bus.stop && (bus.mode != MODE_RSVD) &&
                      (bus.lo_lim < bus.hi_lim);
  assign w_first    = (bus.mode == MODE_HOLD) ?
                      dac_clamp(bus.step, bus.lo_lim, bus.hi_lim) : bus.lo_lim;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= C_MAX;
    end else if (w_capture) begin
      lo_q <= bus.lo_lim;
      hi_q <= bus.hi_lim;
    end
  end
`else
  assign w_lo       = '0;
  assign w_hi       = C_MAX;
  assign w_start_ok = bus.start && !bus.stop && (bus.mode != MODE_RSVD);
  assign w_first    = (bus.mode == MODE_HOLD) ? bus.step : '0;
`endif

  assign w_sum  = {1'b0, data_q} + {1'b0, step_q};
  assign w_diff = data_q - w_lo;

  sample_rate_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .clear (w_capture),
    .div   (div_q),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    stb_d     = 1'b0;
    cyc_d     = cyc_q;
    pend_d    = pend_q;
    w_capture = 1'b0;
    w_wrap    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pend_d = 1'b0;
        if (w_start_ok) begin
          w_capture = 1'b1;
          cyc_d     = '0;
          stb_d     = 1'b1;
          data_d    = w_first;
          state_d   = (bus.mode == MODE_HOLD) ? ST_HOLD : ST_UP;
        end
      end
      ST_UP: begin
        if (bus.stop || pend_q) begin
          state_d = ST_FINISH;
        end else if (w_tick) begin
          stb_d = 1'b1;
          if (mode_q == MODE_SAW) begin
            if (w_sum > {1'b0, w_hi}) begin
              data_d = w_lo;
              w_wrap = 1'b1;
            end else begin
              data_d = w_sum[DATA_W-1:0];
            end
          end else if (w_sum >= {1'b0, w_hi}) begin
            data_d  = w_hi;
            state_d = ST_DOWN;
          end else begin
            data_d = w_sum[DATA_W-1:0];
          end
        end
      end
      ST_DOWN: begin
        if (bus.stop || pend_q) begin
          state_d = ST_FINISH;
        end else if (w_tick) begin
          stb_d = 1'b1;
          if (w_diff <= step_q) begin
            data_d  = w_lo;
            w_wrap  = 1'b1;
            state_d = ST_UP;
          end else begin
            data_d = data_q - step_q;
          end
        end
      end
      ST_HOLD: begin
        if (bus.stop) begin
          state_d = ST_FINISH;
        end else if (w_tick) begin
          stb_d  = 1'b1;
          w_wrap = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        data_d  = C_MID;
        pend_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Ramps show the completing sample for one cycle before finishing; a hold
    // period ends exactly on its tick.
    if (w_wrap) begin
      cyc_d = cyc_q + CNT_W'(1);
      if ((ncyc_q != '0) && (cyc_d == ncyc_q)) begin
        if (state_q == ST_HOLD) begin
          state_d = ST_FINISH;
          stb_d   = 1'b0;
        end else begin
          pend_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.busy       = (state_q != ST_IDLE);
    bus.done       = (state_q == ST_FINISH);
    bus.sample_stb = stb_q || (state_q == ST_FINISH);
    bus.data       = (state_q == ST_FINISH) ? C_MID : data_q;
    bus.control    = DAC_CTRL_STEADY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_SAW;
      step_q <= '0;
      div_q  <= '0;
      ncyc_q <= '0;
      cyc_q  <= '0;
      data_q <= C_MID;
      stb_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      data_q <= data_d;
      stb_q  <= stb_d;
      cyc_q  <= cyc_d;
      pend_q <= pend_d;
      if (w_capture) begin
        mode_q <= bus.mode;
        step_q <= w_step_in;
        div_q  <= bus.div;
        ncyc_q <= bus.n_cycles;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dac_sweep_gen.sv
// ============================================================================
// Module      : tb_dac_sweep_gen
// Description : Directed, scoreboard-checked bench for dac_sweep_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dac_sweep_gen;

  localparam logic [13:0] MID = 14'h1FFF;
  localparam int          MAXV = 16383;

  typedef struct {
    logic [13:0] d;
    int          gap;
    logic        dn;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  dac_sweep_gen_if #(.DATA_W(14), .DIV_W(16), .CNT_W(8)) ifc ();

  dac_sweep_gen #(.DATA_W(14), .DIV_W(16), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input int gap, input logic dn);
    exp_t e;
    e.d   = 14'(d);
    e.gap = gap;
    e.dn  = dn;
    sb.push_back(e);
  endtask

  // Reference sample sequence of one run, including the closing midscale sample.
  task automatic model(input int mode, input int stp, input int dv, input int n);
    int s;
    int d;
    int c;
    bit up;
    s  = (mode != 2 && stp == 0) ? 1 : stp;
    c  = 0;
    up = 1'b1;
    if (mode == 2) begin
      push(stp, 1, 1'b0);
      for (int i = 0; i < n - 1; i++) push(stp, dv + 1, 1'b0);
      push(MID, dv + 1, 1'b1);
    end else begin
      d = 0;
      push(d, 1, 1'b0);
      while (c < n) begin
        if (mode == 0) begin
          if (d + s > MAXV) begin d = 0; c++; end
          else d = d + s;
        end else if (up) begin
          if (d + s >= MAXV) begin d = MAXV; up = 1'b0; end
          else d = d + s;
        end else begin
          if (d <= s) begin d = 0; c++; up = 1'b1; end
          else d = d - s;
        end
        push(d, dv + 1, 1'b0);
      end
      push(MID, 1, 1'b1);
    end
  endtask

  task automatic run(input string tag, input int mode, input int stp, input int dv, input int n);
    int   gap;
    int   budget;
    exp_t e;
    model(mode, stp, dv, n);
    budget        = sb.size() * (dv + 2) + 20;
    ifc.mode      = 2'(mode);
    ifc.step      = 14'(stp);
    ifc.div       = 16'(dv);
    ifc.n_cycles  = 8'(n);
    ifc.start     = 1'b1;
    gap           = 0;
    while (sb.size() > 0 && budget > 0) begin
      step_clk();
      ifc.start = 1'b0;
      gap++;
      budget--;
      if (ifc.sample_stb) begin
        e = sb.pop_front();
        check({tag, "_data"}, 32'(ifc.data), 32'(e.d));
        check({tag, "_gap"},  32'(gap),      32'(e.gap));
        check({tag, "_done"}, 32'(ifc.done), 32'(e.dn));
        check({tag, "_busy"}, 32'(ifc.busy), 32'd1);
        gap = 0;
      end
    end
    check({tag, "_timeout"}, 32'(sb.size()), 32'd0);
    sb.delete();
    step_clk();
    check({tag, "_idle_busy"}, 32'(ifc.busy), 32'd0);
    check({tag, "_idle_data"}, 32'(ifc.data), 32'(MID));
  endtask

  initial begin
    int cnt;
    checks       = 0;
    failures     = 0;
    clk          = 1'b0;
    rst          = 1'b1;
    ifc.start    = 1'b0;
    ifc.stop     = 1'b0;
    ifc.mode     = 2'd0;
    ifc.step     = '0;
    ifc.div      = '0;
    ifc.n_cycles = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_data",    32'(ifc.data),    32'(MID));
    check("rst_control", 32'(ifc.control), 32'd0);
    check("rst_busy",    32'(ifc.busy),    32'd0);
    check("rst_done",    32'(ifc.done),    32'd0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step_clk();
      if (ifc.sample_stb || ifc.busy || ifc.data !== MID) cnt++;
    end
    check("idle_quiet", 32'(cnt), 32'd0);

    run("saw",      0, 4096,  0, 2);
    run("tri",      1, 6000,  3, 1);
    run("hold",     2, 'h123, 9, 5);
    run("saw_edge", 0, MAXV,  1, 3);
    run("tri_edge", 1, MAXV,  0, 2);
    check("ctrl_run", 32'(ifc.control), 32'd0);

    // Free-running sawtooth aborted by stop.
    ifc.mode = 2'd0; ifc.step = 14'd100; ifc.div = '0; ifc.n_cycles = '0;
    ifc.start = 1'b1;
    step_clk();
    ifc.start = 1'b0;
    repeat (36) step_clk();
    check("stop_busy_before", 32'(ifc.busy), 32'd1);
    ifc.stop = 1'b1;
    step_clk();
    ifc.stop = 1'b0;
    check("stop_data", 32'(ifc.data),       32'(MID));
    check("stop_done", 32'(ifc.done),       32'd1);
    check("stop_stb",  32'(ifc.sample_stb), 32'd1);
    step_clk();
    check("stop_idle_busy", 32'(ifc.busy), 32'd0);
    check("stop_idle_done", 32'(ifc.done), 32'd0);

    // Start with stop asserted in the same cycle is ignored.
    ifc.start = 1'b1; ifc.stop = 1'b1;
    step_clk();
    ifc.start = 1'b0; ifc.stop = 1'b0;
    check("startstop_busy", 32'(ifc.busy),       32'd0);
    check("startstop_stb",  32'(ifc.sample_stb), 32'd0);

    // Asynchronous reset between clock edges in the middle of a triangle.
    ifc.mode = 2'd1; ifc.step = 14'd6000; ifc.div = 16'd3; ifc.n_cycles = '0;
    ifc.start = 1'b1;
    step_clk();
    ifc.start = 1'b0;
    repeat (9) step_clk();
    check("arst_busy_before", 32'(ifc.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_data", 32'(ifc.data),       32'(MID));
    check("arst_busy", 32'(ifc.busy),       32'd0);
    check("arst_done", 32'(ifc.done),       32'd0);
    check("arst_stb",  32'(ifc.sample_stb), 32'd0);
    step_clk();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step_clk();
      if (ifc.done || ifc.busy) cnt++;
    end
    check("arst_no_done", 32'(cnt), 32'd0);

    // Reserved mode is never accepted.
    ifc.mode = 2'd3; ifc.step = 14'd5; ifc.start = 1'b1;
    step_clk();
    ifc.start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (ifc.busy || ifc.sample_stb) cnt++;
      step_clk();
    end
    check("mode3_ignored", 32'(cnt), 32'd0);
    check("mode3_data",    32'(ifc.data), 32'(MID));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dac_sweep_gen.md
Name: dac_sweep_gen

Overview:
- Programmable sample source that sits directly upstream of the DAC904 output driver.
- Produces 14-bit offset-binary samples on `data` and a constant `control` = steady (8'd0), so the driver passes `data` straight to the DAC pins.
- Supports sawtooth, triangle and static-level waveforms, with a sample-rate divider and a cycle count.
- Uses a start/stop handshake and reports completion with a `done` pulse.

Parameters:
- DATA_W, 14: sample width; must match the DAC driver data width.
- DIV_W, 16: width of the sample-rate divider.
- CNT_W, 8: width of the waveform-cycle counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled; begins a run when in IDLE.
- stop  in  1  aborts a run.
- mode  in  2  0 = sawtooth, 1 = triangle, 2 = hold level, 3 = reserved.
- step  in  DATA_W  increment per sample (saw/tri); output level in hold mode.
- div  in  DIV_W  sample period = div+1 clocks.
- n_cycles  in  CNT_W  number of waveform cycles; 0 = run until stop.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse at end or abort of a run.
- sample_stb  out  1  one-cycle pulse when `data` takes a new value.
- data  out  DATA_W  sample to the DAC driver.
- control  out  8  driver mode; tied to 8'd0 (steady).

Behaviour:
- Reset values: data = 14'h1FFF (midscale), control = 0, busy = 0, done = 0, sample_stb = 0, state = IDLE, divider = 0, cycle counter = 0.
- States: IDLE, UP, DOWN, HOLD, FINISH.
- IDLE:
  - On start=1, stop=0 and mode != 3: capture mode, step, div and n_cycles into registers. Inputs are not re-sampled mid-run.
  - Next cycle: data = 0 for saw/tri, or data = step for hold. sample_stb pulses and busy rises.
  - Next state: UP for saw/tri, HOLD for hold.
  - mode = 3, or start together with stop: start is ignored and the block stays in IDLE.
- Divider:
  - Counts 0..div_r and emits a tick when count == div_r, then reloads 0.
  - One sample update per tick, so a new sample every div_r+1 clocks; div=0 gives an update every clock.
  - The divider is cleared when a run starts.
- Step rule: a captured step of 0 is treated as 1 in saw/tri modes.
- Arithmetic: sums use DATA_W+1 bits; overflow is detected on the carry or compare, never by silent wrap.
- UP, sawtooth: on each tick, if data + step > 14'h3FFF, then data = 0 and one cycle completes; otherwise data += step.
- UP, triangle: on each tick, if data + step >= 14'h3FFF, then data = 14'h3FFF and the state moves to DOWN; otherwise data += step.
- DOWN, triangle: on each tick, if data <= step, then data = 0, one cycle completes and the state returns to UP; otherwise data -= step.
- HOLD:
  - data stays at the captured step.
  - Each tick counts as one cycle, so n_cycles sets the hold duration in sample periods.
- Completion:
  - When the completed-cycle count reaches n_cycles_r (with n_cycles_r != 0), go to FINISH.
  - The sample that completed the cycle is still output.
- FINISH (one cycle):
  - data = 14'h1FFF with sample_stb=1, and done=1 for one cycle.
  - Then go to IDLE; busy drops on entry to IDLE.
- stop in any run state: the next cycle behaves as FINISH, taking priority over a same-cycle tick.
- start while busy: ignored.
- Asynchronous reset mid-run: outputs return to their reset values immediately. No done pulse is issued.
- `control` is constant 8'd0 in every state.

Optional Feature:
- Macro: DAC_SWEEP_LIMIT_EN.
- Defined:
  - Adds inputs lo_lim[DATA_W-1:0] and hi_lim[DATA_W-1:0], captured at start.
  - Saw/tri use lo_lim and hi_lim in place of 0 and 14'h3FFF: the run starts at lo_lim and wraps or reflects at those bounds.
  - Hold level is clamped into [lo_lim, hi_lim].
  - A start with lo_lim >= hi_lim is ignored.
- Not defined: no extra ports; bounds are fixed at 0 and 14'h3FFF.

Decomposition:
- Package dac_pkg:
  - DAC_W = 14, DAC_MID = 14'h1FFF, DAC_MAX = 14'h3FFF.
  - DAC_CTRL_STEADY = 8'd0, DAC_CTRL_RAMP = 8'd1.
  - Mode encodings MODE_SAW, MODE_TRI, MODE_HOLD.
  - State encoding for the sweep FSM.
- One sub-module, sample_rate_div:
  - Inputs: clk, rst, clear, div.
  - Output: tick.
  - Reused by other sample-paced blocks.

Test Plan:
- Reset then idle → data = 14'h1FFF, control = 0, busy = 0, no sample_stb for 100 clocks.
- Sawtooth, step=4096, div=0, n_cycles=2 → data 0, 4096, 8192, 12288, 0, 4096, 8192, 12288, 0, then 14'h1FFF with done=1. sample_stb is high every cycle of the run.
- Triangle, step=6000, div=3, n_cycles=1 → data 0, 6000, 12000, 16383, 10383, 4383, 0, each held 4 clocks; then midscale and done.
- Hold, step=14'h0123, div=9, n_cycles=5 → data = 14'h0123 for 50 clocks after the first sample, then midscale and done.
- Sawtooth with n_cycles=0, stop after 37 clocks → next cycle data = 14'h1FFF and done=1. Restart with start and stop asserted together → ignored.
- Asynchronous rst asserted mid-triangle between clock edges → data = 14'h1FFF and busy = 0 immediately, with no done pulse. mode=3 start → no response.
